// File: rtl/stage_if_fetch.sv
// MIPS instruction fetch. Holds the PC, keeps one imem request outstanding and parks each returned word in a one-entry slot. IF_DELAY_SLOT_EN selects delay-slot branch redirects.
// Latency: with zero-wait memory, a request issued in cycle N gives a valid slot word from cycle N+2.
// Backpressure: stall[1] holds the slot and stall[0] blocks new requests. A word already in flight is always captured.
module stage_if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  stall,
   input  logic        branch_enable,
   input  logic [31:0] branch_target,
   output logic        imem_request,
   output logic [31:0] imem_address,
   input  logic        imem_ready,
   input  logic        imem_valid,
   input  logic [31:0] imem_read_data,
   output logic [31:0] if_register_pc_read_data,
   output logic [31:0] if_instruction,
   output logic        stall_request
);

   typedef enum logic {ST_FETCH, ST_WAIT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic        slot_valid;
   logic [31:0] slot_pc;
   logic [31:0] slot_instr;
   logic [31:0] inflight_pc;
   logic        kill;

   logic        consume;
   logic        fire;
   logic        response;
   logic        flush_slot;
   logic [31:0] pc_nxt;
   logic        kill_nxt;

`ifdef IF_DELAY_SLOT_EN
   logic        redirect_pending;
   logic [31:0] redirect_target;
   logic        redirect_pending_nxt;
   logic [31:0] redirect_target_nxt;
`endif

   // Only the freeze and latch-hold bits concern this stage.
   logic unused_stall_bits;
   assign unused_stall_bits = ^stall[5:2];

   assign consume  = slot_valid & ~stall[1];
   assign imem_request = reset & (state == ST_FETCH) & ~stall[0] & (~slot_valid | ~stall[1]);
   assign fire     = imem_request & imem_ready;
   assign response = (state == ST_WAIT) & imem_valid;

   assign imem_address             = pc;
   assign if_register_pc_read_data = slot_valid ? slot_pc : 32'h0;
   assign if_instruction           = slot_valid ? slot_instr : 32'h0;
   assign stall_request            = ~slot_valid;

   always_comb begin
      pc_nxt     = pc;
      kill_nxt   = kill;
      flush_slot = 1'b0;
`ifdef IF_DELAY_SLOT_EN
      redirect_pending_nxt = redirect_pending;
      redirect_target_nxt  = redirect_target;
`endif
      if (response)
         kill_nxt = 1'b0;

`ifdef IF_DELAY_SLOT_EN
      if (fire) begin
         if (redirect_pending) begin
            pc_nxt               = redirect_target;
            redirect_pending_nxt = 1'b0;
         end else begin
            pc_nxt = pc + 32'd4;
         end
      end
      if (branch_enable) begin
         // The request still waiting at pc is the delay slot, so the redirect is deferred until it issues.
         if ((state == ST_FETCH) && !slot_valid && !fire) begin
            redirect_pending_nxt = 1'b1;
            redirect_target_nxt  = branch_target;
         end else begin
            pc_nxt               = branch_target;
            redirect_pending_nxt = 1'b0;
         end
         // The consumed slot word was the delay slot, so a request accepted now is wrong-path.
         if (consume && fire)
            kill_nxt = 1'b1;
      end
`else
      if (fire)
         pc_nxt = pc + 32'd4;
      if (branch_enable) begin
         pc_nxt     = branch_target;
         flush_slot = 1'b1;
         // A word returning this very cycle is dropped by the flush, so no kill is needed for it.
         if (((state == ST_WAIT) && !imem_valid) || fire)
            kill_nxt = 1'b1;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_FETCH;
         pc          <= RESET_PC;
         slot_valid  <= 1'b0;
         slot_pc     <= 32'h0;
         slot_instr  <= 32'h0;
         inflight_pc <= 32'h0;
         kill        <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
         redirect_pending <= 1'b0;
         redirect_target  <= 32'h0;
`endif
      end else begin
         pc   <= pc_nxt;
         kill <= kill_nxt;
`ifdef IF_DELAY_SLOT_EN
         redirect_pending <= redirect_pending_nxt;
         redirect_target  <= redirect_target_nxt;
`endif
         if (response && !kill && !flush_slot) begin
            slot_valid <= 1'b1;
            slot_pc    <= inflight_pc;
            slot_instr <= imem_read_data;
         end else if (consume || flush_slot) begin
            slot_valid <= 1'b0;
         end

         case (state)
            ST_FETCH: begin
               if (fire) begin
                  inflight_pc <= pc;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_valid)
                  state <= ST_FETCH;
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_if_fetch.sv
// Bench for stage_if_fetch: a zero-wait memory model returns address-derived words and a scoreboard queue checks each consumed slot word.
module tb_stage_if_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  stall = 6'h0;
   logic        branch_enable = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        imem_request;
   logic [31:0] imem_address;
   logic        mem_ready = 1'b1;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic [31:0] if_register_pc_read_data;
   logic [31:0] if_instruction;
   logic        stall_request;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   stage_if_fetch #(.RESET_PC(RST_PC)) dut (
      .clock(clock),
      .reset(reset),
      .stall(stall),
      .branch_enable(branch_enable),
      .branch_target(branch_target),
      .imem_request(imem_request),
      .imem_address(imem_address),
      .imem_ready(mem_ready),
      .imem_valid(mem_valid),
      .imem_read_data(mem_data),
      .if_register_pc_read_data(if_register_pc_read_data),
      .if_instruction(if_instruction),
      .stall_request(stall_request)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      mem_word = a ^ 32'hA5A5_0000;
   endfunction

   // Zero-wait memory: accepts whenever mem_ready, answers on the following cycle.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_valid <= 1'b0;
         mem_data  <= 32'h0;
      end else begin
         mem_valid <= imem_request && mem_ready;
         mem_data  <= mem_word(imem_address);
      end
   end

   // Called at a falling edge once the inputs for the next rising edge are set.
   // A consumed slot word is scored against the queue head, then time advances one cycle.
   task automatic cycle();
      logic [31:0] a;
      if (reset && !stall_request && !stall[1] && exp_q.size() > 0) begin
         a = exp_q.pop_front();
         vectors++;
         if (if_register_pc_read_data !== a) begin
            miscompares++;
            $display("FAIL slot_pc got %h want %h", if_register_pc_read_data, a);
         end
         vectors++;
         if (if_instruction !== mem_word(a)) begin
            miscompares++;
            $display("FAIL slot_instr got %h want %h", if_instruction, mem_word(a));
         end
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      stall = 6'h0;
      branch_enable = 1'b0;
      branch_target = 32'h0;
      mem_ready = 1'b1;
      exp_q.delete();
      #1;
      cycle();
      cycle();
   endtask

   task automatic release_reset();
      reset = 1'b1;
      #1;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
      ok = (exp_q.size() == 0);
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (imem_request !== 1'b0) begin miscompares++; $display("FAIL rst_request got %b want 0", imem_request); end
      vectors++;
      if (imem_address !== RST_PC) begin miscompares++; $display("FAIL rst_address got %h want %h", imem_address, RST_PC); end
      vectors++;
      if (if_register_pc_read_data !== 32'h0) begin miscompares++; $display("FAIL rst_pc_out got %h want 0", if_register_pc_read_data); end
      vectors++;
      if (if_instruction !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h want 0", if_instruction); end
      vectors++;
      if (stall_request !== 1'b1) begin miscompares++; $display("FAIL rst_stall_req got %b want 1", stall_request); end
   endtask

   task automatic test_sequential();
      bit ok;
      do_reset();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      release_reset();
      vectors++;
      if (imem_request !== 1'b1 || imem_address !== RST_PC) begin
         miscompares++; $display("FAIL seq_first_req got %b/%h want 1/%h", imem_request, imem_address, RST_PC);
      end
      for (int i = 0; i < 8; i++) begin
         cycle();
         vectors++;
         if (stall_request !== ((i % 2) == 0)) begin
            miscompares++; $display("FAIL seq_stall_req cycle %0d got %b want %b", i, stall_request, (i % 2) == 0);
         end
      end
      wait_drain(2, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL seq_drain got words missing want all 3 delivered"); end
   endtask

   task automatic test_ready_low();
      bit ok;
      bit found = 1'b0;
      do_reset();
      for (int a = 0; a <= 16; a += 4) exp_q.push_back(32'(a));
      release_reset();
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         found = imem_request && (imem_address == 32'h10);
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL rdy_reach got no request want request at 00000010"); end
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         vectors++;
         if (imem_request !== 1'b1 || imem_address !== 32'h10) begin
            miscompares++; $display("FAIL rdy_hold_req got %b/%h want 1/00000010", imem_request, imem_address);
         end
         vectors++;
         if (stall_request !== 1'b1) begin miscompares++; $display("FAIL rdy_stall_req got %b want 1", stall_request); end
         vectors++;
         if (if_instruction !== 32'h0) begin miscompares++; $display("FAIL rdy_instr got %h want 0", if_instruction); end
      end
      mem_ready = 1'b1;
      wait_drain(10, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rdy_drain got words missing want 00000010 delivered"); end
   endtask

   task automatic test_hold();
      bit ok;
      bit found = 1'b0;
      do_reset();
      stall = 6'b000010;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      release_reset();
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         found = !stall_request;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL hold_fill got empty slot want full"); end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (if_register_pc_read_data !== 32'h0 || if_instruction !== mem_word(32'h0)) begin
            miscompares++; $display("FAIL hold_word got %h/%h want 00000000/%h", if_register_pc_read_data, if_instruction, mem_word(32'h0));
         end
         vectors++;
         if (imem_request !== 1'b0) begin miscompares++; $display("FAIL hold_no_req got %b want 0", imem_request); end
         cycle();
      end
      stall = 6'h0;
      #1;
      vectors++;
      if (imem_request !== 1'b1 || imem_address !== 32'h4) begin
         miscompares++; $display("FAIL hold_release_req got %b/%h want 1/00000004", imem_request, imem_address);
      end
      cycle();
      vectors++;
      if (stall_request !== 1'b1) begin miscompares++; $display("FAIL hold_consumed got stall_req %b want 1", stall_request); end
      wait_drain(6, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL hold_drain got words missing want 00000004 delivered"); end
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      do_reset();
      stall = 6'b000010;
      release_reset();
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         found = !stall_request;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL arst_fill got empty slot want full"); end
      reset = 1'b0;
      #1;
      vectors++;
      if (if_instruction !== 32'h0 || if_register_pc_read_data !== 32'h0) begin
         miscompares++; $display("FAIL arst_outputs got %h/%h want 0/0", if_register_pc_read_data, if_instruction);
      end
      vectors++;
      if (stall_request !== 1'b1) begin miscompares++; $display("FAIL arst_stall_req got %b want 1", stall_request); end
   endtask

   task automatic test_branch_slot_empty();
      bit ok;
      bit found = 1'b0;
      logic [31:0] want_addr;
      do_reset();
      for (int a = 0; a <= 32; a += 4) exp_q.push_back(32'(a));
`ifdef IF_DELAY_SLOT_EN
      exp_q.push_back(32'h24);
      want_addr = 32'h24;
`else
      want_addr = 32'h100;
`endif
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      release_reset();
      for (int i = 0; i < 60 && !found; i++) begin
         cycle();
         found = imem_request && (imem_address == 32'h24);
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL br_reach got no request want request at 00000024"); end
      mem_ready = 1'b0;
      cycle();
      vectors++;
      if (imem_request !== 1'b1 || imem_address !== 32'h24 || stall_request !== 1'b1) begin
         miscompares++; $display("FAIL br_setup got %b/%h/%b want 1/00000024/1", imem_request, imem_address, stall_request);
      end
      branch_enable = 1'b1;
      branch_target = 32'h100;
      cycle();
      branch_enable = 1'b0;
      mem_ready = 1'b1;
      vectors++;
      if (imem_address !== want_addr) begin miscompares++; $display("FAIL br_next_addr got %h want %h", imem_address, want_addr); end
      wait_drain(20, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL br_drain got words missing want redirect stream delivered"); end
   endtask

   task automatic test_branch_kill_wrap();
      bit ok;
      bit found = 1'b0;
      do_reset();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      release_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = imem_request && (imem_address == 32'h8) && !stall_request;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL kill_reach got no request want request at 00000008"); end
      branch_enable = 1'b1;
      branch_target = 32'hFFFF_FFF8;
      cycle();
      branch_enable = 1'b0;
      vectors++;
      if (imem_request !== 1'b0 || imem_address !== 32'hFFFF_FFF8) begin
         miscompares++; $display("FAIL kill_redirect got %b/%h want 0/fffffff8", imem_request, imem_address);
      end
      wait_drain(30, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL kill_drain got words missing want wrapped stream delivered"); end
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      bit found = 1'b0;
      do_reset();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      release_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = imem_request && (imem_address == 32'h8);
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL rw_reach got no request want request at 00000008"); end
      cycle();
      reset = 1'b0;
      #1;
      vectors++;
      if (imem_request !== 1'b0 || imem_address !== RST_PC) begin
         miscompares++; $display("FAIL rw_request got %b/%h want 0/%h", imem_request, imem_address, RST_PC);
      end
      vectors++;
      if (stall_request !== 1'b1 || if_instruction !== 32'h0) begin
         miscompares++; $display("FAIL rw_outputs got %b/%h want 1/00000000", stall_request, if_instruction);
      end
      cycle();
      exp_q.delete();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      release_reset();
      vectors++;
      if (imem_request !== 1'b1 || imem_address !== RST_PC) begin
         miscompares++; $display("FAIL rw_refetch got %b/%h want 1/%h", imem_request, imem_address, RST_PC);
      end
      wait_drain(20, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rw_drain got words missing want refetch from reset pc"); end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_sequential();
      test_ready_low();
      test_hold();
      test_async_reset();
      test_branch_slot_empty();
      test_branch_kill_wrap();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stage_if_fetch.md
# stage_if_fetch

Instruction-fetch stage of the MIPS pipeline, directly upstream of the IF/ID pipeline latch. It owns the program counter, issues single-outstanding requests to instruction memory over a request/ready/valid handshake, and holds each fetched word in a one-entry output slot until the IF/ID latch consumes it. It raises `stall_request` to the stall controller whenever no instruction is available. Branch redirects from ID are applied with MIPS delay-slot semantics.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clock` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-low; low forces all state to reset values immediately.
- `stall` in 6: pipeline stall vector; bit 0 freezes PC/request issue, bit 1 means the IF/ID latch does not load this edge.
- `branch_enable` in 1: one-cycle redirect pulse from ID.
- `branch_target` in 32: redirect address, valid with `branch_enable`.
- `imem_request` out 1: fetch request.
- `imem_address` out 32: word address of request; equals `pc`.
- `imem_ready` in 1: memory accepts request this cycle.
- `imem_valid` in 1: read data returned this cycle.
- `imem_read_data` in 32: returned instruction word.
- `if_register_pc_read_data` out 32: PC of the slot word; 0 when slot empty.
- `if_instruction` out 32: slot word; 0 (NOP) when slot empty.
- `stall_request` out 1: high while slot empty.

## Operation
- Registers: `pc`, state (FETCH/WAIT), `slot_valid`, `slot_pc`, `slot_instr`, `inflight_pc`, `redirect_pending`, `redirect_target`, `kill`.
- Consume: rising edge with `slot_valid`=1 and `stall[1]`=0.
- FETCH: `imem_request`=1 iff `stall[0]`=0 and (slot empty or consumed this edge). On `imem_request && imem_ready`: `inflight_pc`<=`pc`; `pc`<=`redirect_pending ? redirect_target : pc+4` (clear `redirect_pending`); go WAIT.
- WAIT: `imem_request`=0. On `imem_valid`: if `kill`, drop word, clear `kill`; else load slot (`slot_pc`<=`inflight_pc`, `slot_instr`<=data, `slot_valid`<=1). Go FETCH.
- Slot clears on consume unless reloaded the same edge.
- At most one of {slot word, in-flight word} exists at any time.
- Branch pulse (delay-slot mode): if FETCH and slot empty, the pending request is the delay slot: set `redirect_pending`, `redirect_target`. Otherwise `pc`<=`branch_target` immediately. If the pulse coincides with consume plus an accepted request, that request is wrong-path: set `kill`.
- `pc` arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state FETCH, slot empty, `kill`=0, `redirect_pending`=0; outputs `imem_request`=0 while reset is low, `imem_address`=`RESET_PC`, both `if_*` outputs 0, `stall_request`=1.
- Zero-wait memory (ready same cycle, valid next cycle): request cycle N, slot valid from cycle N+2; peak throughput one instruction per 2 cycles.
- Request held stable (address unchanged) until `imem_ready`; `stall[0]` may drop a not-yet-accepted request.
- `stall` never aborts WAIT; returned word is captured regardless of `stall`.
- Reset low mid-WAIT: transaction abandoned; memory must not return data for it after reset.

## Configuration
- `IF_DELAY_SLOT_EN` defined: delay-slot redirect as above.
- Undefined: branch pulse flushes slot, sets `kill` if WAIT or a request is accepted that cycle, sets `pc`<=`branch_target` immediately; no `redirect_pending` logic.

## Test plan
- Reset release, zero-wait memory returning `pc`-indexed words: addresses 0,4,8 fetched; outputs (0,w0),(4,w1),(8,w2) each valid, `stall_request` low 1 of every 2 cycles.
- `imem_ready` held low 3 cycles at address 0x10: request/address stable, `stall_request`=1, `if_instruction`=0 throughout.
- `stall[1]`=1 for 4 cycles with slot full: outputs hold the same word, no new request; release consumes it once.
- Branch pulse to 0x100 while FETCH at 0x24 with slot empty (delay-slot on): 0x24 fetched, next request 0x100.
- Same pulse with macro off: 0x24 never delivered; next slot word is from 0x100.
- Reset low during WAIT: outputs 0, `stall_request`=1 immediately; refetch starts at `RESET_PC`.
